instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control sequencer for the 16-bit core. It fetches instructions over a single-port memory handshake and holds them in an instruction register that feeds the ALU decoder. It maintains the PC and carry flag, performs the extra memory cycles for ADM/SBM/LDR/STI, and strobes register-file writeback. It owns every memory access; the ALU decoder and datapath stay purely combinational.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  1 = write (STI only)
- mem_addr  out  16  request address
- mem_wdata  out  16  store data (= st_data latched at DECODE)
- mem_rdata  in  16  read data, valid when mem_ack=1
- mem_ack  in  1  completes the pending request; may arrive in the first req cycle
- ir  out  16  instruction register, drives decoder INSTR
- carry  out  1  carry flag, drives decoder CARRY
- mdr  out  16  memory data register (ADM/SBM operand, LDR data)
- alu_result  in  16  datapath result (also LDR/STI effective address)
- alu_cout  in  1  datapath carry-out (after COUTSel)
- st_data  in  16  register value to store for STI
- rf_we  out  1  one-cycle register-file write strobe
- rf_waddr  out  2  destination register
- rf_wsel  out  1  0 = alu_result, 1 = mdr
- pc  out  16  program counter
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Opcode = ir[15:11]. Classes: NOP 00000; ADR 00001; ADM/SBM 0001x/0011x; ADI 00100; SBR 00101; SBI 01000; MLR 01001; XSL 01010; XSR 01011; BBO 01100; LDR 01110; STI 01111; HLT 11111; all others illegal (executed as NOP, illegal pulsed in DECODE).
- States: FETCH, DECODE, MEMRD, EXEC, WB, MEMWR, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack: ir<=mem_rdata, pc<=pc+1 (mod 2^16, FFFF wraps to 0000) -> DECODE.
- DECODE (1 cycle, ir stable): NOP/illegal -> FETCH; HLT -> HALT; ADM/SBM -> MEMRD, addr={8'h00, ir[7:0]}; LDR -> MEMRD, addr=alu_result (latched); STI -> MEMWR, addr=alu_result, wdata=st_data (both latched); other ALU ops -> EXEC.
- MEMRD: mem_req=1, mem_we=0. On ack mdr<=mem_rdata; ADM/SBM -> EXEC, LDR -> WB.
- EXEC (1 cycle): rf_we=1, rf_wsel=0, carry<=alu_cout -> FETCH.
- WB (1 cycle, LDR): rf_we=1, rf_wsel=1, carry unchanged -> FETCH.
- MEMWR: mem_req=1, mem_we=1. On ack -> FETCH. No rf write, carry unchanged.
- rf_waddr: ADR/SBR/MLR/BBO ir[3:2]; ADI/SBI ir[10:9]; ADM/SBM ir[11:10]; XSL/XSR ir[1:0]; LDR ir[7:6]. Don't-care when rf_we=0.
- HALT: absorbing; halted=1; exit only via reset.

## Timing
- Reset values: state FETCH, pc=RESET_PC, ir=0, carry=0, mdr=0, mem_req/mem_we/rf_we/illegal/halted=0, mem_addr=0, mem_wdata=0.
- First mem_req asserts the first clk after reset deassertion.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable from request start until the ack cycle. mem_req drops the cycle after ack; no back-to-back request without an intervening non-memory state.
- Latency with zero-wait ack: register ALU op = 3 cycles (FETCH, DECODE, EXEC); ADM/SBM and LDR = 4; STI = 3; NOP = 2. Each wait cycle extends its state by 1.
- Reset mid-request drops mem_req asynchronously; the pending access is abandoned and a late ack is ignored.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Reset, RESET_PC=0, mem[0]=16'h0800 (ADR), zero-wait: req addr 0 at cycle 1; ir=0800 at DECODE; rf_we in cycle 3; rf_waddr=0; carry=alu_cout; pc=1.
- ADM 16'h1C25, mem[0x25]=0x1234, ack delayed 2 cycles: read addr 0x0025 held 3 cycles; mdr=1234; rf_waddr=3 in EXEC.
- LDR with alu_result=0x0400, mem[0x400]=0xBEEF: rf_we with rf_wsel=1, rf_waddr=ir[7:6], mdr=BEEF; carry unchanged.
- STI with alu_result=0x0010, st_data=0xA5A5: single write req, we=1, addr=0010, wdata=A5A5; no rf_we.
- pc=FFFF, fetch NOP: pc wraps to 0000; opcode 01101 gives one illegal pulse; HLT 16'hF800 gives halted=1 and no further mem_req.
- Assert reset during a waiting FETCH: mem_req=0 immediately; pc=RESET_PC; a later ack causes no ir change.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/memory/writeback sequencer for the 16-bit core.
// Every memory and register-file strobe comes straight from a flop so the bus sees glitch-free, stable requests.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] ir,
    output logic        carry,
    output logic [15:0] mdr,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    input  logic [15:0] st_data,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic        rf_wsel,
    output logic [15:0] pc,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state_dbg
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_WB, S_MEMWR, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_NOP, C_ILL, C_HLT, C_ALU, C_MEM, C_LDR, C_STI
    } class_e;

    function automatic class_e op_class(input logic [4:0] op);
        case (op)
            5'b00000: op_class = C_NOP;
            5'b00001, 5'b00100, 5'b00101, 5'b01000,
            5'b01001, 5'b01010, 5'b01011, 5'b01100: op_class = C_ALU;
            5'b00010, 5'b00011, 5'b00110, 5'b00111: op_class = C_MEM;
            5'b01110: op_class = C_LDR;
            5'b01111: op_class = C_STI;
            5'b11111: op_class = C_HLT;
            default:  op_class = C_ILL;
        endcase
    endfunction

    function automatic logic [1:0] dest_reg(input logic [15:0] instr);
        case (instr[15:11])
            5'b00100, 5'b01000:                     dest_reg = instr[10:9];
            5'b00010, 5'b00011, 5'b00110, 5'b00111: dest_reg = instr[11:10];
            5'b01010, 5'b01011:                     dest_reg = instr[1:0];
            5'b01110:                               dest_reg = instr[7:6];
            default:                                dest_reg = instr[3:2];
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        carry_q, carry_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic        rf_we_q, rf_we_d, rf_wsel_q, rf_wsel_d;
    logic [1:0]  rf_waddr_q, rf_waddr_d;
    logic        halted_q, halted_d, illegal_q, illegal_d;
    logic        acked;
    class_e      cls;

    // Handshake: a transfer completes on a rising edge where mem_req=1 and mem_ack=1;
    // ack with no request outstanding is ignored. After reset or a store, FETCH spends
    // one cycle raising mem_req so requests never run back to back.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        carry_d     = carry_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wsel_d   = rf_wsel_q;
        halted_d    = halted_q;
        illegal_d   = 1'b0;
        acked       = mem_req_q && mem_ack;
        cls         = op_class(ir_q[15:11]);

        case (state_q)
            S_FETCH: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end else if (acked) begin
                    mem_req_d = 1'b0;
                    ir_d      = mem_rdata;
                    pc_d      = pc_q + 16'd1;
                    illegal_d = (op_class(mem_rdata[15:11]) == C_ILL);
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_HLT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    C_MEM, C_LDR: begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = (cls == C_MEM) ? {8'h00, ir_q[7:0]} : alu_result;
                        state_d    = S_MEMRD;
                    end
                    C_STI: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = alu_result;
                        mem_wdata_d = st_data;
                        state_d     = S_MEMWR;
                    end
                    C_ALU: begin
                        rf_we_d    = 1'b1;
                        rf_wsel_d  = 1'b0;
                        rf_waddr_d = dest_reg(ir_q);
                        state_d    = S_EXEC;
                    end
                    default: begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = pc_q;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMRD: begin
                if (acked) begin
                    mem_req_d  = 1'b0;
                    mdr_d      = mem_rdata;
                    rf_we_d    = 1'b1;
                    rf_wsel_d  = (cls == C_LDR);
                    rf_waddr_d = dest_reg(ir_q);
                    state_d    = (cls == C_LDR) ? S_WB : S_EXEC;
                end
            end
            S_EXEC, S_WB: begin
                if (state_q == S_EXEC) carry_d = alu_cout;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_q;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                if (acked) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 16'h0000;
            mdr_q       <= 16'h0000;
            carry_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 2'd0;
            rf_wsel_q   <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            carry_q     <= carry_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wsel_q   <= rf_wsel_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ir        = ir_q;
    assign carry     = carry_q;
    assign mdr       = mdr_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wsel   = rf_wsel_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: random program plus directed instructions, an instruction-level
// reference model that predicts the bus/writeback event stream, and a monitor that checks it.
`timescale 1ns/1ps
module tb_instr_sequencer;
    localparam logic [15:0] RESET_PC = 16'hFFF0;
    localparam int EW = 55;
    localparam logic [1:0] K_REQ = 2'd0, K_RF = 2'd1, K_ILL = 2'd2;

    logic        clk = 1'b0, reset = 1'b1;
    logic        mem_req, mem_we, mem_ack, alu_cout, rf_we, rf_wsel, carry, halted, illegal;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, ir, mdr, alu_result, st_data, pc;
    logic [1:0]  rf_waddr;
    logic [2:0]  state_dbg;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] wr_mem  [logic [15:0]];
    logic [EW-1:0] exp_q[$];
    logic [15:0] exp_pc;
    int n_checks = 0, n_fail = 0, cyc = 0, rsp_mode = 0;
    int first_req_cyc = -1, first_rf_cyc = -1;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    // Datapath stand-in: LDR/STI addresses always land in 0x8000-0xBFFF, away from code.
    function automatic logic [15:0] dp_addr(input logic [15:0] i, input logic [15:0] m);
        return {2'b10, i[13:0] ^ m[13:0]};
    endfunction
    function automatic logic dp_cout(input logic [15:0] i, input logic [15:0] m);
        return i[0] ^ i[5] ^ m[0];
    endfunction
    function automatic logic [15:0] dp_st(input logic [15:0] i, input logic [15:0] m);
        return i ^ m ^ 16'h3C3C;
    endfunction

    assign alu_result = dp_addr(ir, mdr);
    assign alu_cout   = dp_cout(ir, mdr);
    assign st_data    = dp_st(ir, mdr);

    instr_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir), .carry(carry),
        .mdr(mdr), .alu_result(alu_result), .alu_cout(alu_cout), .st_data(st_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .pc(pc), .halted(halted),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    function automatic logic [EW-1:0] mk_ev(input logic [1:0] k, input logic we, input logic [15:0] a,
                                            input logic [15:0] wd, input logic c, input logic [1:0] wa,
                                            input logic ws, input logic [15:0] md);
        return {k, we, a, wd, c, wa, ws, md};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [EW-1:0] act, output logic [EW-1:0] ex);
        ex = '0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected event %h, expected none", name, act);
        end else begin
            ex = exp_q.pop_front();
            check(name, 64'(act), 64'(ex));
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        if (r[15:11] == 5'b11111) r[15:11] = 5'b00000;
        return r;
    endfunction

    // Reference model: executes the program one instruction at a time and lists the
    // externally visible events each instruction must produce, in order.
    task automatic build_model();
        logic [15:0] p, instr, a, d, m;
        logic [4:0]  op;
        logic [1:0]  dst;
        logic        c;
        p = RESET_PC; m = 16'h0; c = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 1000; n++) begin
            instr = ref_mem[p];
            exp_q.push_back(mk_ev(K_REQ, 1'b0, p, 16'h0, c, 2'd0, 1'b0, 16'h0));
            p = p + 16'd1;
            op = instr[15:11];
            if (op inside {5'b00100, 5'b01000}) dst = instr[10:9];
            else if (op inside {5'b00010, 5'b00011, 5'b00110, 5'b00111}) dst = instr[11:10];
            else if (op inside {5'b01010, 5'b01011}) dst = instr[1:0];
            else if (op == 5'b01110) dst = instr[7:6];
            else dst = instr[3:2];
            if (op == 5'b11111) break;
            if (op inside {5'b00010, 5'b00011, 5'b00110, 5'b00111}) begin
                a = {8'h00, instr[7:0]};
                exp_q.push_back(mk_ev(K_REQ, 1'b0, a, 16'h0, c, 2'd0, 1'b0, 16'h0));
                m = ref_mem[a];
                exp_q.push_back(mk_ev(K_RF, 1'b0, 16'h0, 16'h0, 1'b0, dst, 1'b0, 16'h0));
                c = dp_cout(instr, m);
            end else if (op == 5'b01110) begin
                a = dp_addr(instr, m);
                exp_q.push_back(mk_ev(K_REQ, 1'b0, a, 16'h0, c, 2'd0, 1'b0, 16'h0));
                m = ref_mem[a];
                exp_q.push_back(mk_ev(K_RF, 1'b0, 16'h0, 16'h0, 1'b0, dst, 1'b1, m));
            end else if (op == 5'b01111) begin
                a = dp_addr(instr, m);
                d = dp_st(instr, m);
                exp_q.push_back(mk_ev(K_REQ, 1'b1, a, d, c, 2'd0, 1'b0, 16'h0));
                ref_mem[a] = d;
            end else if (op inside {5'b00001, 5'b00100, 5'b00101, 5'b01000, 5'b01001,
                                    5'b01010, 5'b01011, 5'b01100}) begin
                exp_q.push_back(mk_ev(K_RF, 1'b0, 16'h0, 16'h0, 1'b0, dst, 1'b0, 16'h0));
                c = dp_cout(instr, m);
            end else if (op != 5'b00000) begin
                exp_q.push_back(mk_ev(K_ILL, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 16'h0));
            end
        end
        exp_pc = p;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Memory responder: mode 0 silent, mode 1 acks only while no request is pending,
    // mode 2 normal with random wait states and stray acks between requests.
    initial begin
        int wait_cnt, nreq;
        bit in_req;
        mem_ack = 1'b0; mem_rdata = 16'h0; in_req = 1'b0; nreq = 0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset || rsp_mode == 0) begin
                mem_ack = 1'b0;
                in_req = 1'b0;
            end else if (rsp_mode == 1) begin
                mem_ack = !mem_req;
                mem_rdata = 16'hDEAD;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    in_req = 1'b0;
                end
                if (mem_req && !in_req) begin
                    in_req = 1'b1;
                    wait_cnt = (nreq == 0) ? 0 : $urandom_range(0, 3);
                    nreq++;
                end
                if (in_req) begin
                    if (wait_cnt == 0) begin
                        mem_ack = 1'b1;
                        if (mem_we) wr_mem[mem_addr] = mem_wdata;
                        else mem_rdata = wr_mem.exists(mem_addr) ? wr_mem[mem_addr] : mem[mem_addr];
                    end else begin
                        wait_cnt--;
                        mem_rdata = 16'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // Monitor: compares each observed event with the head of the expected queue.
    initial begin
        logic [EW-1:0] act, cur;
        logic req_prev;
        req_prev = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                req_prev = 1'b0;
            end else begin
                act = mk_ev(K_REQ, mem_we, mem_addr, mem_we ? mem_wdata : 16'h0, carry, 2'd0, 1'b0, 16'h0);
                if (mem_req && !req_prev) begin
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    pop_cmp("mem_req_start", act, cur);
                end else if (mem_req) begin
                    check("mem_req_hold", 64'(act), 64'(cur));
                end
                if (rf_we) begin
                    if (first_rf_cyc < 0) first_rf_cyc = cyc;
                    act = mk_ev(K_RF, 1'b0, 16'h0, 16'h0, 1'b0, rf_waddr, rf_wsel, rf_wsel ? mdr : 16'h0);
                    pop_cmp("rf_write", act, act);
                end
                if (illegal) begin
                    act = mk_ev(K_ILL, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 16'h0);
                    pop_cmp("illegal_pulse", act, act);
                end
                if (cyc == 2) check("ir_at_decode", ir, 16'h0800);
                req_prev = mem_req;
            end
        end
    end

    initial begin
        bit got, no_req;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 16'hFFF5; i <= 16'hFFFE; i++) mem[i] = rand_instr();
        for (int i = 0; i < 16'h0040; i++) mem[i] = rand_instr();
        mem[16'hFFF0] = 16'h0800;   // ADR
        mem[16'hFFF1] = 16'h1CF5;   // ADM, dest 3, operand at 0x00F5
        mem[16'hFFF2] = 16'h70C0;   // LDR, dest 3
        mem[16'hFFF3] = 16'h7800;   // STI
        mem[16'hFFF4] = 16'h6800;   // undefined opcode 01101
        mem[16'hFFFF] = 16'h0000;   // NOP across the pc wrap
        mem[16'h0040] = 16'hF800;   // HLT
        mem[16'h00F5] = 16'h1234;
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        build_model();

        repeat (3) @(posedge clk);
        #2;
        check("rst_pc", pc, RESET_PC);
        check("rst_ir", ir, 16'h0);
        check("rst_mdr", mdr, 16'h0);
        check("rst_flags", {carry, mem_req, mem_we, rf_we, illegal, halted}, 6'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        reset = 1'b0;

        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            got = mem_req;
        end
        check("fetch_req_after_reset", got, 1'b1);
        check("fetch_addr", mem_addr, RESET_PC);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("req_drop_async", mem_req, 1'b0);
        check("pc_after_mid_reset", pc, RESET_PC);
        rsp_mode = 1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("late_ack_ir", ir, 16'h0);
        check("req_after_ignored_ack", mem_req, 1'b1);

        @(posedge clk);
        #2 reset = 1'b1;
        rsp_mode = 2;
        mon_en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 20000 && !halted; i++) @(negedge clk);
        check("halted", halted, 1'b1);
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("final_pc", pc, exp_pc);
        check("final_ir", ir, 16'hF800);
        check("first_req_cycle", first_req_cyc, 1);
        check("first_rf_we_cycle", first_rf_cyc, 3);
        no_req = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) no_req = 1'b0;
        end
        check("no_req_in_halt", no_req, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
